msu_data_fetch: RTL and testbench

Downstream stage of the MSU register block. It consumes the MSU data-track seek and advance pulses, pulls 512-byte sectors of the data file from the HPS SD-style sector interface into a ping-pong buffer, and presents the byte at the current read pointer on `data`. It keeps one sector of prefetch ahead so that sequential reads through $2001 stream without stalls.

---
 rtl/msu_data_fetch_if.sv | 30 +++
 rtl/msu_data_fetch.sv | 138 +++++++++++++
 tb/tb_msu_data_fetch.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/msu_data_fetch_if.sv
// MSU data-track fetch bus: the MSU-side seek/advance handshake plus the
// host sector-transfer port. master = the fetch block, slave = its peers.
interface msu_data_fetch_if #(
   parameter int SECTOR_BITS = 9
);
   logic [31:0]            data_addr;
   logic                   data_seek;
   logic                   data_req;
   logic [7:0]             data;
   logic                   data_ack;
   logic                   underrun;
   logic [31:0]            sd_lba;
   logic                   sd_rd;
   logic                   sd_ack;
   logic [SECTOR_BITS-1:0] sd_buff_addr;
   logic [7:0]             sd_buff_dout;
   logic                   sd_buff_wr;

   modport master (
      input  data_addr, data_seek, data_req,
      input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
      output data, data_ack, underrun, sd_lba, sd_rd
   );

   modport slave (
      output data_addr, data_seek, data_req,
      output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
      input  data, data_ack, underrun, sd_lba, sd_rd
   );
endinterface

// File: rtl/msu_data_fetch.sv
// MSU data-track sector fetch: ping-pong sector buffer with one sector of
// prefetch so sequential byte reads stream without stalls.
module msu_data_fetch #(
   parameter int          SECTOR_BITS = 9,
   parameter logic [31:0] LBA_BASE    = 32'd0
) (
   input logic            CLK,
   input logic            RESET,
   msu_data_fetch_if.master bus
);
   localparam int SECT = 1 << SECTOR_BITS;

   typedef enum logic [2:0] {
      S_IDLE, S_DRAIN, S_LOAD_CUR, S_WAIT_CUR, S_ACK, S_PREFETCH, S_READY
   } state_t;

   state_t                 state, state_nx;
   logic [7:0]             ram [0:2*SECT-1];
   logic [7:0]             rd_q;
   logic [31:0]            seek_lba;
   logic [SECTOR_BITS-1:0] ptr;
   logic                   cur;
   logic [1:0]             valid;
   logic [31:0]            lba_half [2];
   logic                   ld_half, ld_abort;
   logic [31:0]            ld_target;
   logic                   busy;          // one request outstanding until its sd_ack falls
   logic                   seek_q, ack_q;
   logic [1:0]             ack_cnt;
   logic                   issue, issue_half;
   logic [31:0]            issue_lba;

   logic seek_edge, ack_rise, land, req_ok, wrap, wr_en;
   assign seek_edge = bus.data_seek & ~seek_q;
   assign ack_rise  = bus.sd_ack & ~ack_q;
   assign land      = ~bus.sd_ack & ack_q & busy;
   assign req_ok    = bus.data_req & ~seek_edge & ((state == S_READY) || (state == S_PREFETCH));
   assign wrap      = req_ok & (ptr == '1);
   // Strobes from a transfer we no longer own (e.g. after reset) are dropped.
   assign wr_en     = bus.sd_ack & bus.sd_buff_wr & busy & ~RESET;

   // Sector buffer: host writes on one port, registered read of the current byte on the other.
   always_ff @(posedge CLK) begin
      if (wr_en) ram[{ld_half, bus.sd_buff_addr}] <= bus.sd_buff_dout;
      rd_q <= ram[{cur, ptr}];
   end

   // Next state and request issue; a seek edge overrides whatever the FSM was doing.
   always_comb begin
      state_nx   = state;
      issue      = 1'b0;
      issue_half = cur;
      issue_lba  = seek_lba;
      if (seek_edge) begin
         state_nx = busy ? S_DRAIN : S_LOAD_CUR;
      end else begin
         case (state)
            S_IDLE:     state_nx = S_IDLE;
            S_DRAIN:    if (!busy) state_nx = S_LOAD_CUR;
            S_LOAD_CUR: if (!busy && !bus.sd_ack) begin
               issue    = 1'b1;
               state_nx = S_WAIT_CUR;
            end
            S_WAIT_CUR: if (valid[cur]) state_nx = S_ACK;
            S_ACK:      if (ack_cnt == 2'd2) state_nx = S_PREFETCH;
            S_PREFETCH: if (!busy && !bus.sd_ack) begin
               issue      = 1'b1;
               issue_half = ~cur;
               issue_lba  = lba_half[cur] + 32'd1;
               state_nx   = S_READY;
            end
            S_READY:    if (!valid[~cur] && !busy) state_nx = S_PREFETCH;
            default:    state_nx = S_IDLE;
         endcase
      end
   end

   // State, host handshake, buffer bookkeeping and read pointer.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state         <= S_IDLE;
         seek_q        <= 1'b0;
         ack_q         <= 1'b0;
         ack_cnt       <= 2'd0;
         busy          <= 1'b0;
         valid         <= 2'b00;
         ptr           <= '0;
         cur           <= 1'b0;
         ld_abort      <= 1'b0;
         seek_lba      <= 32'd0;
         bus.data      <= 8'd0;
         bus.data_ack  <= 1'b0;
         bus.underrun  <= 1'b0;
         bus.sd_lba    <= 32'd0;
         bus.sd_rd     <= 1'b0;
      end else begin
         state        <= state_nx;
         seek_q       <= bus.data_seek;
         ack_q        <= bus.sd_ack;
         ack_cnt      <= (state == S_ACK) ? ack_cnt + 2'd1 : 2'd0;
         bus.data     <= rd_q;
         bus.data_ack <= (state == S_ACK) && (ack_cnt == 2'd2) && !seek_edge;

         if (ack_rise && busy) bus.sd_rd <= 1'b0;
         if (issue) begin
            bus.sd_rd  <= 1'b1;
            bus.sd_lba <= LBA_BASE + issue_lba;
            busy       <= 1'b1;
            ld_half    <= issue_half;
            ld_target  <= issue_lba;
         end
         if (land) begin
            busy              <= 1'b0;
            valid[ld_half]    <= ~ld_abort;
            lba_half[ld_half] <= ld_target;
         end
         if (state == S_DRAIN && !busy) ld_abort <= 1'b0;

         if (req_ok) begin
            ptr <= ptr + 1'b1;
            if (wrap) begin
               cur        <= ~cur;
               valid[cur] <= 1'b0;
               if (!valid[~cur]) bus.underrun <= 1'b1;
            end
         end

         if (seek_edge) begin
            ptr          <= bus.data_addr[SECTOR_BITS-1:0];
            seek_lba     <= bus.data_addr >> SECTOR_BITS;
            valid        <= 2'b00;
            bus.underrun <= 1'b0;
            cur          <= 1'b0;
            if (busy) ld_abort <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_msu_data_fetch.sv
// Bench for msu_data_fetch: host sector model plus a byte-address reference model.
module tb_msu_data_fetch;
   logic CLK = 1'b0;
   logic RESET = 1'b1;
   int   total = 0;
   int   bad = 0;

   always #5 CLK = ~CLK;

   msu_data_fetch_if #(.SECTOR_BITS(9)) bus ();
   msu_data_fetch_if #(.SECTOR_BITS(9)) bus_b ();

   msu_data_fetch #(.SECTOR_BITS(9), .LBA_BASE(32'd0))   u_dut   (.CLK(CLK), .RESET(RESET), .bus(bus.master));
   msu_data_fetch #(.SECTOR_BITS(9), .LBA_BASE(32'd100)) u_dut_b (.CLK(CLK), .RESET(RESET), .bus(bus_b.master));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // sector contents served by the host: sector 2 holds byte==index
   function automatic logic [7:0] pat(input logic [31:0] lba, input int i);
      logic [31:0] t;
      t = 32'(i) + (lba - 32'd2) * 32'd37;
      return t[7:0];
   endfunction

   // reference: byte at a logical data-file address (LBA_BASE = 0)
   function automatic logic [7:0] exp_byte(input logic [31:0] a);
      return pat(a >> 9, int'(a & 32'h1FF));
   endfunction

   // host model
   logic [31:0] req_log [$];
   int          land_cnt = 0;
   logic [31:0] last_land_lba = 32'd0;
   logic [31:0] xfer_lba = 32'd0;
   int          xfer_idx = -1;
   logic [31:0] slow_lba = 32'hFFFF_FFFF;
   int          slow_delay = 0;
   int          rnd_max = 0;
   int          ack_pulses = 0;

   initial begin
      bus.sd_ack = 1'b0; bus.sd_buff_wr = 1'b0; bus.sd_buff_addr = '0; bus.sd_buff_dout = 8'd0;
      forever begin
         @(negedge CLK);
         if (bus.sd_rd === 1'b1 && bus.sd_ack === 1'b0) begin
            logic [31:0] lba;
            int dly;
            lba = bus.sd_lba;
            req_log.push_back(lba);
            xfer_lba = lba;
            dly = (lba == slow_lba) ? slow_delay : int'($urandom_range(0, rnd_max));
            repeat (dly) @(negedge CLK);
            bus.sd_ack = 1'b1;
            for (int i = 0; i < 512; i++) begin
               @(negedge CLK);
               xfer_idx = i;
               bus.sd_buff_addr = 9'(i);
               bus.sd_buff_dout = pat(lba, i);
               bus.sd_buff_wr = 1'b1;
            end
            @(negedge CLK);
            bus.sd_buff_wr = 1'b0;
            bus.sd_ack = 1'b0;
            xfer_idx = -1;
            last_land_lba = lba;
            land_cnt++;
         end
      end
   end

   always @(negedge CLK) if (bus.data_ack === 1'b1) ack_pulses++;

   task automatic do_seek(input logic [31:0] addr, input string tag);
      int n;
      n = 0;
      @(negedge CLK);
      bus.data_addr = addr;
      bus.data_seek = 1'b1;
      do begin @(negedge CLK); n++; end while (bus.data_ack !== 1'b1 && n < 10000);
      chk({tag, "_ack"}, 32'(n < 10000), 32'd1);
      bus.data_seek = 1'b0;
   endtask

   task automatic do_req(input int gap);
      @(negedge CLK); bus.data_req = 1'b1;
      @(negedge CLK); bus.data_req = 1'b0;
      repeat (gap) @(negedge CLK);
   endtask

   task automatic wait_reqs(input int cnt, input string tag);
      int n;
      n = 0;
      while (req_log.size() < cnt && n < 5000) begin @(negedge CLK); n++; end
      chk({tag, "_req"}, 32'(req_log.size() >= cnt), 32'd1);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ack"},   32'(bus.data_ack), 32'd0);
      chk({tag, "_rd"},    32'(bus.sd_rd),    32'd0);
      chk({tag, "_lba"},   bus.sd_lba,        32'd0);
      chk({tag, "_under"}, 32'(bus.underrun), 32'd0);
      chk({tag, "_data"},  32'(bus.data),     32'd0);
   endtask

   task automatic b_xfer(input logic [31:0] lba);
      @(negedge CLK); bus_b.sd_ack = 1'b1;
      for (int i = 0; i < 512; i++) begin
         @(negedge CLK);
         bus_b.sd_buff_addr = 9'(i);
         bus_b.sd_buff_dout = pat(lba, i);
         bus_b.sd_buff_wr = 1'b1;
      end
      @(negedge CLK); bus_b.sd_buff_wr = 1'b0; bus_b.sd_ack = 1'b0;
   endtask

   initial begin
      int n, n0, a0, lc0, nreq;
      logic [31:0] addr;
      bus.data_addr = 32'd0; bus.data_seek = 1'b0; bus.data_req = 1'b0;
      bus_b.data_addr = 32'd0; bus_b.data_seek = 1'b0; bus_b.data_req = 1'b0;
      bus_b.sd_ack = 1'b0; bus_b.sd_buff_addr = '0; bus_b.sd_buff_dout = 8'd0; bus_b.sd_buff_wr = 1'b0;

      RESET = 1'b1;
      repeat (4) @(negedge CLK);
      chk_reset_vals("rst");
      RESET = 1'b0;

      // 1: seek into sector 2, then prefetch of sector 3
      do_seek(32'h405, "t1");
      chk("t1_data", 32'(bus.data), 32'h05);
      wait_reqs(2, "t1_pf");
      chk("t1_lba0", req_log[0], 32'd2);
      chk("t1_lba1", req_log[1], 32'd3);

      // 2: stream across the sector boundary
      addr = 32'h405;
      for (int k = 0; k < 510; k++) begin
         do_req(2);
         addr++;
         chk("t2_data", 32'(bus.data), 32'(exp_byte(addr)));
      end
      chk("t2_under", 32'(bus.underrun), 32'd0);
      wait_reqs(3, "t2_pf");
      chk("t2_lba", req_log[2], 32'd4);

      // 3: cross before the prefetch lands
      slow_lba = 32'd3; slow_delay = 2000;
      do_seek(32'h5FE, "t3");
      lc0 = land_cnt;
      chk("t3_data0", 32'(bus.data), 32'(pat(2, 510)));
      do_req(2);
      chk("t3_data1", 32'(bus.data), 32'(pat(2, 511)));
      do_req(2);
      chk("t3_under", 32'(bus.underrun), 32'd1);
      n = 0;
      while (land_cnt == lc0 && n < 5000) begin @(negedge CLK); n++; end
      chk("t3_land", last_land_lba, 32'd3);
      repeat (3) @(negedge CLK);
      chk("t3_late_data", 32'(bus.data), 32'(pat(3, 0)));
      chk("t3_under_sticky", 32'(bus.underrun), 32'd1);
      slow_lba = 32'hFFFF_FFFF;
      do_seek(32'hA00, "t3b");
      chk("t3_under_clr", 32'(bus.underrun), 32'd0);
      chk("t3b_data", 32'(bus.data), 32'(pat(5, 0)));

      // 4: seek while the sector 6 prefetch is mid-transfer
      n = 0;
      while (!(xfer_lba == 32'd6 && xfer_idx >= 100) && n < 5000) begin @(negedge CLK); n++; end
      chk("t4_mid", 32'(n < 5000), 32'd1);
      n0 = req_log.size();
      a0 = ack_pulses;
      do_seek(32'h1000, "t4");
      chk("t4_data", 32'(bus.data), 32'(pat(8, 0)));
      chk("t4_lba", req_log[n0], 32'd8);
      wait_reqs(n0 + 2, "t4_pf");
      chk("t4_lba_pf", req_log[n0 + 1], 32'd9);
      chk("t4_acks", 32'(ack_pulses - a0), 32'd1);
      for (int k = 1; k <= 3; k++) begin
         do_req(2);
         chk("t4_step", 32'(bus.data), 32'(pat(8, k)));
      end

      // random seeks and sequential streams against the address model
      rnd_max = 20;
      for (int it = 0; it < 6; it++) begin
         addr = ($urandom & 32'h003F_FE00) | 32'($urandom_range(0, 300));
         do_seek(addr, "rnd");
         chk("rnd_seek_data", 32'(bus.data), 32'(exp_byte(addr)));
         nreq = int'($urandom_range(0, 700));
         for (int k = 0; k < nreq; k++) begin
            do_req(int'($urandom_range(2, 4)));
            addr++;
            chk("rnd_data", 32'(bus.data), 32'(exp_byte(addr)));
         end
         chk("rnd_under", 32'(bus.underrun), 32'd0);
      end
      rnd_max = 0;

      // 5: LBA_BASE offset on the second instance
      bus_b.data_addr = 32'd0; bus_b.data_seek = 1'b1;
      n = 0;
      while (bus_b.sd_rd !== 1'b1 && n < 100) begin @(negedge CLK); n++; end
      chk("t5_lba0", bus_b.sd_lba, 32'd100);
      b_xfer(32'd100);
      n = 0;
      while (bus_b.data_ack !== 1'b1 && n < 100) begin @(negedge CLK); n++; end
      chk("t5_ack", 32'(n < 100), 32'd1);
      chk("t5_data", 32'(bus_b.data), 32'(pat(100, 0)));
      bus_b.data_seek = 1'b0;
      n = 0;
      while (bus_b.sd_rd !== 1'b1 && n < 100) begin @(negedge CLK); n++; end
      chk("t5_lba1", bus_b.sd_lba, 32'd101);

      // 6: reset in the middle of a host transfer
      do_seek(32'h3000, "t6a");
      n = 0;
      while (!(xfer_lba == 32'h19 && xfer_idx >= 50) && n < 5000) begin @(negedge CLK); n++; end
      chk("t6_mid", 32'(n < 5000), 32'd1);
      RESET = 1'b1;
      repeat (3) @(negedge CLK);
      chk_reset_vals("t6_rst");
      RESET = 1'b0;
      n0 = req_log.size();
      do_seek(32'h2345, "t6");
      chk("t6_data", 32'(bus.data), 32'(pat(32'h11, 32'h145)));
      chk("t6_lba", req_log[n0], 32'h11);
      addr = 32'h2345;
      for (int k = 0; k < 2; k++) begin
         do_req(2);
         addr++;
         chk("t6_step", 32'(bus.data), 32'(exp_byte(addr)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
